sram_dp_responder: RTL and testbench
====================================

# sram_dp_responder

Behavioral dual-port SRAM responder serving the initiator-side SRAM interface driven by the AER event FIFO wrapper: port A and port B chip-enable/address/write-enable/byte-mask/data strobes in, registered read data out. It models the byte-addressed, one-cycle-latency macro the FIFO expects. It adds a deterministic collision policy, a sequenced memory-clear engine, and error/statistics outputs for bring-up and verification.

## Interface
Parameters:
- DWIDTH, 64, data width per port in bits; multiple of 8.
- DEPTH, 64, byte address space per port; power of two, at least DWIDTH/8.
- AWIDTH (local), $clog2(DEPTH), address width.
- WMASK (local), DWIDTH/8, byte-mask width.
- NWORDS (local), DEPTH/WMASK, number of storage words.
- OFS (local), $clog2(WMASK), number of byte-offset address bits.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_clr  in  1  one-cycle request to zero all words and clear misalign_err.
- ce_a, ce_b  in  1  port chip enable.
- we_a, we_b  in  1  write enable; 1 = write, 0 = read (qualified by ce).
- addr_a, addr_b  in  AWIDTH  byte address; word index = addr[AWIDTH-1:OFS].
- wmask_a, wmask_b  in  WMASK  byte write enables; bit i covers data[8i+7:8i].
- wdata_a, wdata_b  in  DWIDTH  write data.
- rdata_a, rdata_b  out  DWIDTH  registered read data.
- init_busy  out  1  clear engine active.
- coll_cnt  out  8  saturating count of same-word collision cycles.
- misalign_err  out  1  sticky flag; an access had nonzero addr[OFS-1:0].

## Operation
- Read: ce_x=1 and we_x=0 loads rdata_x with word[index_x] at the edge. rdata_x holds its value in all other cycles, including write cycles on the same port.
- Write: ce_x=1 and we_x=1 updates only the bytes whose wmask_x bit is 1. wmask_x=0 with we_x=1 is a legal no-op write.
- Misaligned address: the access proceeds on the truncated word index. misalign_err is set the following cycle.
- Collision: both ports enabled, same word index, at least one port writing. Both ports reading the same word is not a collision.
  - Write/read collision: the read port returns pre-write data. This is read-first behaviour; the Configuration section describes the alternative.
  - Write/write collision: port A wins each byte enabled on both ports. Bytes enabled only on B take wdata_b.
  - coll_cnt increments by 1 per collision cycle and saturates at 255.
- Clear engine states:
  - IDLE: mem_clr=1 moves to CLEAR, sets clr_idx=0 and clears misalign_err.
  - CLEAR: writes 0 to word[clr_idx] each cycle and increments clr_idx. After word NWORDS-1 is written, moves to IDLE.
  - mem_clr while in CLEAR is ignored.
- While init_busy=1:
  - Port writes are dropped.
  - Port reads load rdata_x=0.
  - Collision and misalignment are not recorded.
- Storage array has no reset. Contents after power-up are undefined until written or cleared.

## Timing
- Reset values: rdata_a=0, rdata_b=0, init_busy=0, coll_cnt=0, misalign_err=0; FSM=IDLE; clr_idx=0.
- Read latency: 1 cycle. Address presented at edge N gives data on rdata after edge N.
- Write visibility: a write at edge N is readable by either port at edge N+1. Back-to-back write then read of the same word returns new data.
- init_busy goes high one cycle after mem_clr and stays high for exactly NWORDS cycles.
- rst_n asserted mid-clear aborts the clear: FSM goes to IDLE, and words not yet cleared keep stale contents.
- coll_cnt and misalign_err update one cycle after the offending access.

## Configuration
- SRAM_RW_BYPASS_EN defined: in a write/read collision, the read port returns merged data.
  - Bytes enabled by the writer's mask take the writer's wdata; remaining bytes take old contents.
  - In a write/write collision, the bypass value is the port-A-wins merge.
  - coll_cnt still counts these cycles.
- SRAM_RW_BYPASS_EN undefined: read-first behaviour as in Operation.

## Test plan
- Write 0x1122334455667788 to addr_a=0x08 (wmask FF), then read addr_b=0x08 -> rdata_b = 0x1122334455667788 one cycle after the read.
- Partial write wmask_a=0x0F, wdata 0xAAAA_AAAA_BBBB_BBBB over 0x1122334455667788 -> read gives 0x11223344BBBBBBBB.
- Same cycle: A writes 0xDEAD (mask FF) to 0x10 while B reads 0x10, old value 0. Without the macro, rdata_b=0; with it, rdata_b=0xDEAD; coll_cnt=1 in both builds.
- Both ports write 0x18: A mask 0x01 data ..01, B mask 0x03 data ..0202 -> word low bytes 0x0201; after 300 such collision cycles coll_cnt=255.
- mem_clr with DEPTH=64 -> init_busy high 8 cycles and all words read 0. A write during busy is lost, a misaligned read at addr 0x03 sets misalign_err, and a second mem_clr clears the flag.
- rst_n pulse during cycle 3 of the clear -> all outputs return to reset values, words 3..7 retain their prior data.

Source files
------------

// File: rtl/sram_dp_responder.sv
// Behavioral dual-port byte-masked SRAM with one-cycle read latency and a clear engine.
// Optional define SRAM_RW_BYPASS_EN: write/read collisions forward merged write data.
module sram_dp_responder #(
   parameter  int DWIDTH = 64,
   parameter  int DEPTH  = 64,
   localparam int AWIDTH = $clog2(DEPTH),
   localparam int WMASK  = DWIDTH / 8,
   localparam int NWORDS = DEPTH / WMASK,
   localparam int OFS    = $clog2(WMASK)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_clr,
   input  logic              ce_a,
   input  logic              ce_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [AWIDTH-1:0] addr_a,
   input  logic [AWIDTH-1:0] addr_b,
   input  logic [WMASK-1:0]  wmask_a,
   input  logic [WMASK-1:0]  wmask_b,
   input  logic [DWIDTH-1:0] wdata_a,
   input  logic [DWIDTH-1:0] wdata_b,
   output logic [DWIDTH-1:0] rdata_a,
   output logic [DWIDTH-1:0] rdata_b,
   output logic              init_busy,
   output logic [7:0]        coll_cnt,
   output logic              misalign_err
);

   localparam int IW = (AWIDTH > OFS) ? (AWIDTH - OFS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);
   localparam logic [AWIDTH-1:0] OFS_MASK = AWIDTH'(WMASK - 1);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t state, state_nxt;
   logic [IW-1:0] clr_idx, clr_idx_nxt;
   logic clr_start, clr_we, busy;

   logic [DWIDTH-1:0] mem [NWORDS];

   logic [IW-1:0] idx_a, idx_b;
   logic rd_a, rd_b, wr_a, wr_b;
   logic same_idx, coll, mis;
   logic [DWIDTH-1:0] merged, rd_val_a, rd_val_b;

   assign busy      = (state == CLEAR);
   assign init_busy = busy;

   assign idx_a = IW'(addr_a >> OFS);
   assign idx_b = IW'(addr_b >> OFS);

   assign rd_a = ce_a & ~we_a & ~busy;
   assign rd_b = ce_b & ~we_b & ~busy;
   assign wr_a = ce_a & we_a & ~busy;
   assign wr_b = ce_b & we_b & ~busy;

   assign same_idx = (idx_a == idx_b);
   assign coll     = ce_a & ce_b & same_idx & (we_a | we_b) & ~busy;
   assign mis      = ~busy & ((ce_a & (|(addr_a & OFS_MASK)))
                            | (ce_b & (|(addr_b & OFS_MASK))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      clr_start   = 1'b0;
      clr_we      = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_clr) begin
               state_nxt   = CLEAR;
               clr_idx_nxt = '0;
               clr_start   = 1'b1;
            end
         end
         CLEAR: begin
            clr_we      = 1'b1;
            clr_idx_nxt = clr_idx + IW'(1);
            if (clr_idx == LAST) begin
               state_nxt   = IDLE;
               clr_idx_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // B is applied first so A's bytes override on a shared word
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else begin
         for (int i = 0; i < WMASK; i++) begin
            if (wr_b && wmask_b[i])
               mem[idx_b][8*i +: 8] <= wdata_b[8*i +: 8];
            if (wr_a && wmask_a[i])
               mem[idx_a][8*i +: 8] <= wdata_a[8*i +: 8];
         end
      end
   end

   // Port-A-wins merge of both writes onto the shared word
   always_comb begin
      merged = mem[idx_a];
      for (int i = 0; i < WMASK; i++) begin
         if (wr_b && same_idx && wmask_b[i])
            merged[8*i +: 8] = wdata_b[8*i +: 8];
         if (wr_a && wmask_a[i])
            merged[8*i +: 8] = wdata_a[8*i +: 8];
      end
   end

   always_comb begin
      rd_val_a = mem[idx_a];
      rd_val_b = mem[idx_b];
`ifdef SRAM_RW_BYPASS_EN
      if (coll) begin
         rd_val_a = merged;
         rd_val_b = merged;
      end
`else
      if (coll && 1'b0) begin
         rd_val_a = merged;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         if (busy && ce_a && !we_a)
            rdata_a <= '0;
         else if (rd_a)
            rdata_a <= rd_val_a;
         if (busy && ce_b && !we_b)
            rdata_b <= '0;
         else if (rd_b)
            rdata_b <= rd_val_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_cnt     <= '0;
         misalign_err <= 1'b0;
      end else begin
         if (coll && (coll_cnt != 8'hFF))
            coll_cnt <= coll_cnt + 8'd1;
         if (clr_start)
            misalign_err <= 1'b0;
         else if (mis)
            misalign_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_dp_responder.sv
// Scoreboard bench for sram_dp_responder (default DWIDTH=64, DEPTH=64).
// Expected read data is queued when a read is driven and popped a cycle later.
module tb_sram_dp_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_clr;
   logic        ce_a, ce_b, we_a, we_b;
   logic [5:0]  addr_a, addr_b;
   logic [7:0]  wmask_a, wmask_b;
   logic [63:0] wdata_a, wdata_b;
   logic [63:0] rdata_a, rdata_b;
   logic        init_busy;
   logic [7:0]  coll_cnt;
   logic        misalign_err;

   int vec = 0;
   int err = 0;

   logic [63:0] model [8];
   logic [63:0] exp_a [$];
   logic [63:0] exp_b [$];

   sram_dp_responder dut (
      .clk(clk), .rst_n(rst_n), .mem_clr(mem_clr),
      .ce_a(ce_a), .ce_b(ce_b), .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b),
      .wmask_a(wmask_a), .wmask_b(wmask_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b),
      .init_busy(init_busy), .coll_cnt(coll_cnt),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      mem_clr = 0;
      ce_a = 0; we_a = 0; addr_a = 0; wmask_a = 0; wdata_a = 0;
      ce_b = 0; we_b = 0; addr_b = 0; wmask_b = 0; wdata_b = 0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] merge(logic [63:0] old, logic [7:0] m,
                                         logic [63:0] d);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++)
         if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic drv_wr_a(logic [5:0] a, logic [7:0] m, logic [63:0] d);
      ce_a = 1; we_a = 1; addr_a = a; wmask_a = m; wdata_a = d;
      model[a[5:3]] = merge(model[a[5:3]], m, d);
   endtask

   task automatic drv_wr_b(logic [5:0] a, logic [7:0] m, logic [63:0] d);
      ce_b = 1; we_b = 1; addr_b = a; wmask_b = m; wdata_b = d;
      model[a[5:3]] = merge(model[a[5:3]], m, d);
   endtask

   task automatic drv_rd_a(logic [5:0] a);
      ce_a = 1; we_a = 0; addr_a = a;
      exp_a.push_back(model[a[5:3]]);
   endtask

   task automatic drv_rd_b(logic [5:0] a);
      ce_b = 1; we_b = 0; addr_b = a;
      exp_b.push_back(model[a[5:3]]);
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      #12;
      vec++;
      if (rdata_a !== 64'h0) begin
         err++; $display("FAIL reset_rdata_a: got %h want 0", rdata_a);
      end
      vec++;
      if (rdata_b !== 64'h0) begin
         err++; $display("FAIL reset_rdata_b: got %h want 0", rdata_b);
      end
      vec++;
      if (init_busy !== 1'b0) begin
         err++; $display("FAIL reset_init_busy: got %b want 0", init_busy);
      end
      vec++;
      if (coll_cnt !== 8'd0) begin
         err++; $display("FAIL reset_coll_cnt: got %0d want 0", coll_cnt);
      end
      vec++;
      if (misalign_err !== 1'b0) begin
         err++; $display("FAIL reset_misalign: got %b want 0", misalign_err);
      end
      @(negedge clk);
      rst_n = 1;
      step();
   endtask

   task automatic test_write_read();
      logic [63:0] e;
      drv_wr_a(6'h08, 8'hFF, 64'h1122334455667788);
      step();
      idle();
      drv_rd_b(6'h08);
      step();
      idle();
      e = exp_b.pop_front();
      vec++;
      if (rdata_b !== e || e !== 64'h1122334455667788) begin
         err++; $display("FAIL write_read: got %h want %h", rdata_b, e);
      end
   endtask

   task automatic test_partial();
      logic [63:0] e;
      drv_wr_a(6'h08, 8'h0F, 64'hAAAAAAAABBBBBBBB);
      step();
      idle();
      drv_rd_a(6'h08);
      step();
      idle();
      e = exp_a.pop_front();
      vec++;
      if (rdata_a !== e || e !== 64'h11223344BBBBBBBB) begin
         err++; $display("FAIL partial: got %h want %h", rdata_a, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] e;
      drv_wr_a(6'h20, 8'hFF, 64'h4444_0000_4444_0004);
      step();
      idle();
      drv_rd_b(6'h20);
      drv_wr_a(6'h28, 8'hFF, 64'h5555_0000_5555_0005);
      step();
      idle();
      e = exp_b.pop_front();
      vec++;
      if (rdata_b !== e) begin
         err++; $display("FAIL b2b_read_b: got %h want %h", rdata_b, e);
      end
      drv_rd_a(6'h28);
      drv_rd_b(6'h28);
      step();
      idle();
      e = exp_a.pop_front();
      vec++;
      if (rdata_a !== e) begin
         err++; $display("FAIL b2b_read_a: got %h want %h", rdata_a, e);
      end
      e = exp_b.pop_front();
      vec++;
      if (rdata_b !== e) begin
         err++; $display("FAIL b2b_dual_read: got %h want %h", rdata_b, e);
      end
      vec++;
      if (coll_cnt !== 8'd0) begin
         err++; $display("FAIL rr_not_coll: got %0d want 0", coll_cnt);
      end
      drv_wr_a(6'h30, 8'hFF, 64'h6666_0000_6666_0006);
      step();
      idle();
      vec++;
      if (rdata_a !== 64'h5555_0000_5555_0005) begin
         err++; $display("FAIL rdata_hold: got %h want %h", rdata_a,
                         64'h5555_0000_5555_0005);
      end
   endtask

   task automatic test_rw_collision();
      logic [63:0] e;
      drv_wr_a(6'h10, 8'hFF, 64'h0);
      step();
      idle();
`ifdef SRAM_RW_BYPASS_EN
      exp_b.push_back(64'hDEAD);
`else
      exp_b.push_back(64'h0);
`endif
      ce_b = 1; we_b = 0; addr_b = 6'h10;
      drv_wr_a(6'h10, 8'hFF, 64'hDEAD);
      step();
      idle();
      e = exp_b.pop_front();
      vec++;
      if (rdata_b !== e) begin
         err++; $display("FAIL rw_coll_rdata: got %h want %h", rdata_b, e);
      end
      vec++;
      if (coll_cnt !== 8'd1) begin
         err++; $display("FAIL rw_coll_cnt: got %0d want 1", coll_cnt);
      end
      drv_rd_b(6'h10);
      step();
      idle();
      e = exp_b.pop_front();
      vec++;
      if (rdata_b !== e || e !== 64'hDEAD) begin
         err++; $display("FAIL rw_coll_after: got %h want %h", rdata_b, e);
      end
   endtask

   task automatic test_ww_collision();
      logic [63:0] e;
      drv_wr_a(6'h18, 8'hFF, 64'h0);
      step();
      idle();
      drv_wr_b(6'h18, 8'h03, 64'h0202);
      drv_wr_a(6'h18, 8'h01, 64'h0001);
      step();
      idle();
      vec++;
      if (coll_cnt !== 8'd2) begin
         err++; $display("FAIL ww_coll_cnt: got %0d want 2", coll_cnt);
      end
      drv_rd_a(6'h18);
      step();
      idle();
      e = exp_a.pop_front();
      vec++;
      if (rdata_a !== e || e !== 64'h0201) begin
         err++; $display("FAIL ww_merge: got %h want %h", rdata_a, e);
      end
      for (int k = 0; k < 300; k++) begin
         drv_wr_b(6'h18, 8'h03, 64'h0202);
         drv_wr_a(6'h18, 8'h01, 64'h0001);
         step();
         idle();
         if (k == 9) begin
            vec++;
            if (coll_cnt !== 8'd12) begin
               err++; $display("FAIL coll_cnt_mid: got %0d want 12", coll_cnt);
            end
         end
      end
      vec++;
      if (coll_cnt !== 8'd255) begin
         err++; $display("FAIL coll_cnt_sat: got %0d want 255", coll_cnt);
      end
   endtask

   task automatic test_clear();
      logic [63:0] e;
      int n;
      for (int i = 0; i < 8; i++) begin
         drv_wr_a(6'(i * 8), 8'hFF, 64'hC0DE_0000_0000_0000 | 64'(i));
         step();
      end
      idle();
      mem_clr = 1;
      step();
      mem_clr = 0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (!init_busy) break;
         n++;
         if (k == 0) begin
            ce_a = 1; we_a = 1; addr_a = 6'h08; wmask_a = 8'hFF;
            wdata_a = 64'hFFFF_FFFF_FFFF_FFFF;
            ce_b = 1; we_b = 0; addr_b = 6'h01;
         end
         step();
         idle();
         if (k == 0) begin
            vec++;
            if (rdata_b !== 64'h0) begin
               err++; $display("FAIL busy_read: got %h want 0", rdata_b);
            end
            vec++;
            if (misalign_err !== 1'b0) begin
               err++; $display("FAIL busy_misalign: got %b want 0", misalign_err);
            end
         end
      end
      vec++;
      if (n !== 8) begin
         err++; $display("FAIL busy_cycles: got %0d want 8", n);
      end
      for (int i = 0; i < 8; i++) model[i] = 64'h0;
      for (int i = 0; i < 8; i++) begin
         drv_rd_a(6'(i * 8));
         step();
         idle();
         e = exp_a.pop_front();
         vec++;
         if (rdata_a !== e) begin
            err++; $display("FAIL clear_word%0d: got %h want %h", i, rdata_a, e);
         end
      end
      drv_rd_a(6'h03);
      step();
      idle();
      e = exp_a.pop_front();
      vec++;
      if (rdata_a !== e) begin
         err++; $display("FAIL misalign_rd: got %h want %h", rdata_a, e);
      end
      vec++;
      if (misalign_err !== 1'b1) begin
         err++; $display("FAIL misalign_set: got %b want 1", misalign_err);
      end
      mem_clr = 1;
      step();
      mem_clr = 0;
      vec++;
      if (misalign_err !== 1'b0 || init_busy !== 1'b1) begin
         err++; $display("FAIL misalign_clr: got %b/%b want 0/1",
                         misalign_err, init_busy);
      end
      n = 0;
      while (init_busy && n < 20) begin
         step();
         n++;
      end
      vec++;
      if (init_busy !== 1'b0) begin
         err++; $display("FAIL clear_timeout: got busy %b want 0", init_busy);
      end
   endtask

   task automatic test_reset_mid_clear();
      logic [63:0] e;
      for (int i = 0; i < 8; i++) begin
         drv_wr_a(6'(i * 8), 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(i));
         step();
      end
      idle();
      drv_rd_a(6'h38);
      drv_rd_b(6'h30);
      step();
      idle();
      e = exp_a.pop_front();
      vec++;
      if (rdata_a !== e) begin
         err++; $display("FAIL pre_rst_a: got %h want %h", rdata_a, e);
      end
      e = exp_b.pop_front();
      vec++;
      if (rdata_b !== e) begin
         err++; $display("FAIL pre_rst_b: got %h want %h", rdata_b, e);
      end
      mem_clr = 1;
      step();
      mem_clr = 0;
      step();
      step();
      step();
      for (int i = 0; i < 3; i++) model[i] = 64'h0;
      rst_n = 0;
      #1;
      vec++;
      if (rdata_a !== 64'h0 || rdata_b !== 64'h0) begin
         err++; $display("FAIL rst_rdata: got %h/%h want 0/0", rdata_a, rdata_b);
      end
      vec++;
      if (init_busy !== 1'b0 || coll_cnt !== 8'd0 || misalign_err !== 1'b0) begin
         err++; $display("FAIL rst_status: got %b/%0d/%b want 0/0/0",
                         init_busy, coll_cnt, misalign_err);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 8; i++) begin
         drv_rd_b(6'(i * 8));
         step();
         idle();
         e = exp_b.pop_front();
         vec++;
         if (rdata_b !== e) begin
            err++; $display("FAIL abort_word%0d: got %h want %h", i, rdata_b, e);
         end
      end
      vec++;
      if (init_busy !== 1'b0) begin
         err++; $display("FAIL abort_idle: got %b want 0", init_busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model[i] = 64'h0;
      test_reset();
      test_write_read();
      test_partial();
      test_back_to_back();
      test_rw_collision();
      test_ww_collision();
      test_clear();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
